dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  AW, 32, address width
  DW, 32, data width
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  asynchronous, active-low reset
  r0_req / r1_req  in  1  access request; held high until the matching gnt
  r0_we / r1_we  in  1  1 = store, 0 = load
  r0_func3 / r1_func3  in  3  RV32 load/store funct3
  r0_addr / r1_addr  in  AW  byte address
  r0_wdata / r1_wdata  in  DW  store data
  r0_gnt / r1_gnt  out  1  one-cycle grant pulse; request fields sampled this cycle
  r0_rvalid / r1_rvalid  out  1  one-cycle response pulse
  r0_rdata / r1_rdata  out  DW  load data, valid with rvalid
  r0_err / r1_err  out  1  misaligned or illegal access, valid with rvalid
  mem_addr  out  AW  to data memory addr
  mem_func3  out  3  to data memory func3
  mem_wdata  out  DW  to data memory wdata
  mem_wen  out  1  to data memory dmwen
  mem_rdata  in  DW  combinational read data from data memory

Function
REQ-003 The block SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-004 In IDLE with any rN_req high, the block SHALL pulse exactly one rN_gnt combinationally, latch that requester's we/func3/addr/wdata and owner ID at the clock edge, and leave IDLE.
REQ-005 Arbitration SHALL be round-robin: if both requesters ask, the requester not granted last wins; if only one asks, it wins; last_gnt SHALL update only on a grant.
REQ-006 At grant, the access SHALL be flagged misaligned if func3[1:0]=01 and addr[0]=1, or func3[1:0]=10 and addr[1:0]!=00; func3[1:0]=11 SHALL be flagged illegal.
REQ-007 A flagged access SHALL go IDLE->RESP, skip ACCESS, never assert mem_wen, and return err=1 with rdata=0.
REQ-008 An unflagged access SHALL go IDLE->ACCESS->RESP->IDLE.
REQ-009 In ACCESS, mem_addr/mem_func3/mem_wdata SHALL drive the latched values, and mem_wen SHALL equal the latched we for exactly that one cycle.
REQ-010 In ACCESS on a load, mem_rdata SHALL be registered at the clock edge as response data; a store SHALL register response data 0.
REQ-011 In RESP, only the owner's rvalid SHALL be 1, with rdata/err driven for that one cycle; non-owner rdata/err/rvalid SHALL be 0.
REQ-012 mem_wen SHALL be 0 in every state other than ACCESS; mem_addr/func3/wdata SHALL hold the last latched values outside ACCESS.
REQ-013 No gnt SHALL be issued in ACCESS or RESP, so unflagged accesses complete every 3 cycles and flagged ones every 2 cycles.
REQ-014 A request still high when the FSM returns to IDLE SHALL be arbitrated in that same IDLE cycle, with no idle gap.
REQ-015 Load rdata SHALL be passed through unmodified; sign/zero extension belongs to the data memory.

Reset
REQ-016 While rst_n=0, asynchronously: state=IDLE, last_gnt=1 (so r0 wins the first tie), and all outputs plus latched fields SHALL be 0.
REQ-017 A reset asserted during ACCESS SHALL deassert mem_wen immediately and drop the pending response; no rvalid SHALL follow.

Verification
REQ-018 r0 store we=1, func3=010, addr=0x0, wdata=0x00111170 -> r0_gnt on cycle 0, mem_wen=1 with mem_addr=0x0 on cycle 1, r0_rvalid=1 with err=0 on cycle 2.
REQ-019 r1 load func3=000, addr=0x1, mem_rdata=0x70 -> r1_rvalid with r1_rdata=0x70 on cycle 2 and mem_wen=0 throughout.
REQ-020 r0 and r1 request simultaneously from reset and hold -> grants ordered r0, r1, r0, with grants 3 cycles apart and no overlapping rvalid.
REQ-021 r0 word load at addr=0x2 -> r0_rvalid with err=1 and rdata=0 one cycle after gnt, and mem_wen is never asserted.
REQ-022 rst_n pulsed low during ACCESS of a store -> mem_wen falls immediately, no rvalid follows, and the next grant after reset goes to r0 on a tie.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two-requester data-memory bus between requesters, arbiter and data memory
// Signals: r0_*/r1_* req/we/func3/addr/wdata in, gnt/rvalid/rdata/err back;
//          mem_addr/mem_func3/mem_wdata/mem_wen to memory, mem_rdata from memory.
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          r0_req, r1_req;
    logic          r0_we, r1_we;
    logic [2:0]    r0_func3, r1_func3;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt;
    logic          r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          r0_err, r1_err;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_func3;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_func3, r1_func3,
               r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rdata,
        output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               r0_err, r1_err, mem_addr, mem_func3, mem_wdata, mem_wen
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_func3, r1_func3,
               r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rdata,
        input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               r0_err, r1_err, mem_addr, mem_func3, mem_wdata, mem_wen
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data memory between two requesters
// Ports: clk (rising edge), rst_n (async active-low),
//        bus (dmem_arbiter_if.slave): requester handshakes r0_*/r1_* and memory side mem_*.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        r_state;
    logic          r_last, r_own, r_we, r_wen, r_err, r_rv0, r_rv1;
    logic [2:0]    r_f3;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;

    logic          w_go, w_pick1, w_we, w_bad;
    logic [2:0]    w_f3;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // r1 wins when it asks alone, or on a tie when r0 was granted last
    assign w_pick1 = bus.r1_req & (~bus.r0_req | ~r_last);
    // grants are suppressed during reset so every output reads 0 while rst_n is low
    assign w_go    = rst_n & (r_state == IDLE) & (bus.r0_req | bus.r1_req);
    assign w_we    = w_pick1 ? bus.r1_we    : bus.r0_we;
    assign w_f3    = w_pick1 ? bus.r1_func3 : bus.r0_func3;
    assign w_addr  = w_pick1 ? bus.r1_addr  : bus.r0_addr;
    assign w_wdata = w_pick1 ? bus.r1_wdata : bus.r0_wdata;
    // size code 11 is illegal; halfword needs addr[0]=0, word needs addr[1:0]=00
    assign w_bad   = (w_f3[1:0] == 2'b11)
                   | ((w_f3[1:0] == 2'b10) & (w_addr[1:0] != 2'b00))
                   | ((w_f3[1:0] == 2'b01) & w_addr[0]);

    assign bus.r0_gnt    = w_go & ~w_pick1;
    assign bus.r1_gnt    = w_go & w_pick1;
    assign bus.r0_rvalid = r_rv0;
    assign bus.r1_rvalid = r_rv1;
    assign bus.r0_rdata  = r_rdata & {DW{r_rv0}};
    assign bus.r1_rdata  = r_rdata & {DW{r_rv1}};
    assign bus.r0_err    = r_err & r_rv0;
    assign bus.r1_err    = r_err & r_rv1;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_func3 = r_f3;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wen   = r_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_own   <= 1'b0;
            r_we    <= 1'b0;
            r_wen   <= 1'b0;
            r_err   <= 1'b0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_go) begin
                    r_last  <= w_pick1;
                    r_own   <= w_pick1;
                    r_we    <= w_we;
                    r_f3    <= w_f3;
                    r_addr  <= w_addr;
                    r_wdata <= w_wdata;
                    if (w_bad) begin
                        r_state <= RESP;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_rv0   <= ~w_pick1;
                        r_rv1   <= w_pick1;
                    end else begin
                        r_state <= ACCESS;
                        r_wen   <= w_we;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    r_wen   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= r_we ? '0 : bus.mem_rdata;
                    r_rv0   <= ~r_own;
                    r_rv1   <= r_own;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_rv0   <= 1'b0;
                    r_rv1   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    bit          p [2];
    bit          m_we [2];
    logic [2:0]  m_f3 [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    int          m_last = 1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
    dmem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // memory contents as a pure function of the address
    function automatic logic [31:0] memv(input logic [31:0] a);
        return (a == 32'h1) ? 32'h70 : (a ^ 32'h5A5A_0F0F);
    endfunction

    assign bus.mem_rdata = memv(bus.mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        p[i] = 1'b1; m_we[i] = we; m_f3[i] = f3; m_addr[i] = a; m_wd[i] = d;
        if (i == 0) begin
            bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_func3 = f3; bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_func3 = f3; bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    task automatic drop(input int i);
        p[i] = 1'b0;
        if (i == 0) bus.r0_req = 1'b0;
        else bus.r1_req = 1'b0;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    endtask

    // Called just after a rising edge with the DUT idle and at least one request pending.
    // Predicts winner, latency and response from the arbitration and alignment rules.
    task automatic serve(input bit keep);
        int w;
        bit bad;
        logic [31:0] exp_rd;
        w = (p[0] && p[1]) ? (m_last == 1 ? 0 : 1) : (p[0] ? 0 : 1);
        bad = (m_f3[w][1:0] == 2'b11) || ((m_addr[w] % (32'd1 << m_f3[w][1:0])) != 0);
        exp_rd = (bad || m_we[w]) ? 32'h0 : memv(m_addr[w]);
        @(negedge clk);
        chk("gnt0", 32'(bus.r0_gnt), 32'(w == 0));
        chk("gnt1", 32'(bus.r1_gnt), 32'(w == 1));
        @(posedge clk); #1;
        m_last = w;
        if (!keep) drop(w);
        if (!bad) begin
            @(negedge clk);
            chk("acc_wen", 32'(bus.mem_wen), 32'(m_we[w]));
            chk("acc_addr", bus.mem_addr, m_addr[w]);
            chk("acc_f3", 32'(bus.mem_func3), 32'(m_f3[w]));
            chk("acc_wdata", bus.mem_wdata, m_wd[w]);
            chk("acc_nognt", 32'({bus.r0_gnt, bus.r1_gnt}), 32'h0);
            chk("acc_norv", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rv0", 32'(bus.r0_rvalid), 32'(w == 0));
        chk("rv1", 32'(bus.r1_rvalid), 32'(w == 1));
        chk("rd0", bus.r0_rdata, (w == 0) ? exp_rd : 32'h0);
        chk("rd1", bus.r1_rdata, (w == 1) ? exp_rd : 32'h0);
        chk("err0", 32'(bus.r0_err), 32'(w == 0 && bad));
        chk("err1", 32'(bus.r1_err), 32'(w == 1 && bad));
        chk("resp_wen", 32'(bus.mem_wen), 32'h0);
        chk("resp_nognt", 32'({bus.r0_gnt, bus.r1_gnt}), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_func3 = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_func3 = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
        // reset state, including no grant while held in reset
        #2;
        bus.r0_req = 1'b1;
        #1;
        chk("rst_gnt0", 32'(bus.r0_gnt), 32'h0);
        chk("rst_wen", 32'(bus.mem_wen), 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rv", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'h0);
        chk("rst_rd0", bus.r0_rdata, 32'h0);
        bus.r0_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // r0 word store
        set_req(0, 1'b1, 3'b010, 32'h0, 32'h0011_1170);
        serve(0);
        // r1 byte load from odd address
        set_req(1, 1'b0, 3'b000, 32'h1, 32'h0);
        serve(0);
        // simultaneous held requests from a fresh reset
        rst_n = 1'b0; m_last = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 1'b0, 3'b100, 32'h10, 32'h0);
        set_req(1, 1'b0, 3'b001, 32'h22, 32'h0);
        serve(1);
        serve(1);
        serve(1);
        drop(0); drop(1);
        // misaligned word load
        set_req(0, 1'b0, 3'b010, 32'h2, 32'h0);
        serve(0);
        // illegal size and misaligned halfword store
        set_req(1, 1'b1, 3'b011, 32'h8, 32'h1234);
        serve(0);
        set_req(0, 1'b1, 3'b001, 32'h5, 32'h5678);
        serve(0);
        // reset during the ACCESS of a store
        set_req(0, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("r22_gnt", 32'(bus.r0_gnt), 32'h1);
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        chk("r22_wen_on", 32'(bus.mem_wen), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("r22_wen_async", 32'(bus.mem_wen), 32'h0);
        chk("r22_addr_clr", bus.mem_addr, 32'h0);
        m_last = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("r22_norv", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'h0);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 3'b010, 32'h80, 32'h0);
        set_req(1, 1'b0, 3'b010, 32'h84, 32'h0);
        serve(0);
        serve(0);
        // randomized traffic; losers stay pending and are arbitrated without a gap
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < 2; i++)
                if (!p[i] && $urandom_range(0, 1) == 1) rand_req(i);
            if (!p[0] && !p[1]) rand_req(int'($urandom_range(0, 1)));
            serve(0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
